vga_stream_arbiter: RTL

- Shares the single 6-bit valid/ready pixel link into vga_controller between two pixel sources.
  - Source 0: GPU rasterizer output.
  - Source 1: overlay/test-pattern source.
- Ownership changes only on frame boundaries, so vga_controller never receives a frame mixed from both sources.
- Tracks the x/y raster position of the stream, registers the output, and reports frame completion.
- Clocked in the clk_20 domain, between tt_um_pongsagon_tiniest_gpu / overlay and vga_controller.

---
 rtl/vga_stream_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/vga_stream_arbiter.sv
// vga_stream_arbiter: frame-granular 2:1 arbiter onto the vga_controller pixel link, with raster tracking.
// Optional underrun fill on owner starvation is enabled by defining ARB_UNDERRUN_FILL_EN.
module vga_stream_arbiter #(
   parameter int H_PIXELS = 160,
   parameter int V_LINES = 120,
   parameter int FILL_TIMEOUT = 16,
   parameter logic [5:0] FILL_COLOR = 6'h00
) (
   input  logic       clk_20,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       sel_req,
   input  logic       s0_valid,
   input  logic [5:0] s0_data,
   output logic       s0_ready,
   input  logic       s1_valid,
   input  logic [5:0] s1_data,
   output logic       s1_ready,
   input  logic       vga_ready_in,
   output logic       vga_data_valid_out,
   output logic [5:0] vga_data_out,
   output logic       owner,
   output logic       busy,
   output logic [7:0] pix_x,
   output logic [7:0] pix_y,
   output logic       frame_done,
   output logic [7:0] frame_cnt,
   output logic [7:0] underrun_cnt
);
   typedef enum logic {IDLE, RUN} state_t;
   localparam logic [7:0] X_LAST = 8'(H_PIXELS - 1);
   localparam logic [7:0] Y_LAST = 8'(V_LINES - 1);
   state_t state, state_nxt;
   logic run, can_load, src_valid, accept, fill, load, boundary;
   logic [5:0] src_data;
   assign run = state == RUN;
   assign can_load = !vga_data_valid_out || vga_ready_in;
   assign src_valid = owner ? s1_valid : s0_valid;
   assign src_data = owner ? s1_data : s0_data;
   assign s0_ready = run && !owner && can_load;
   assign s1_ready = run && owner && can_load;
   assign accept = run && can_load && src_valid;
   assign load = accept || fill;
   assign boundary = load && pix_x == X_LAST && pix_y == Y_LAST;
   assign busy = run;
`ifdef ARB_UNDERRUN_FILL_EN
   logic [15:0] starve;
   logic [7:0] underrun;
   assign fill = run && can_load && !src_valid && starve == 16'(FILL_TIMEOUT);
   assign underrun_cnt = underrun;
   always_ff @(posedge clk_20 or negedge rst_n) begin
      if (!rst_n) begin
         starve <= '0;
         underrun <= '0;
      end else begin
         if (!run || load) starve <= '0;
         else if (can_load) starve <= starve + 16'd1;
         if (fill && underrun != 8'hFF) underrun <= underrun + 8'd1;
      end
   end
`else
   logic unused_fill;
   assign fill = 1'b0;
   assign underrun_cnt = 8'h00;
   assign unused_fill = FILL_TIMEOUT == 0;
`endif
   always_ff @(posedge clk_20 or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      if (!run && enable) state_nxt = RUN;
      else if (boundary && !enable) state_nxt = IDLE;
   end
   always_ff @(posedge clk_20 or negedge rst_n) begin
      if (!rst_n) begin
         owner <= 1'b0;
         pix_x <= '0;
         pix_y <= '0;
         frame_done <= 1'b0;
         frame_cnt <= '0;
         vga_data_valid_out <= 1'b0;
         vga_data_out <= '0;
      end else begin
         frame_done <= boundary;
         if (!run && enable) begin
            owner <= sel_req;
            pix_x <= '0;
            pix_y <= '0;
         end
         if (load) begin
            vga_data_out <= fill ? FILL_COLOR : src_data;
            vga_data_valid_out <= 1'b1;
            pix_x <= pix_x == X_LAST ? '0 : pix_x + 8'd1;
            if (pix_x == X_LAST) pix_y <= pix_y == Y_LAST ? '0 : pix_y + 8'd1;
         end else if (vga_ready_in) vga_data_valid_out <= 1'b0;
         // owner switches only here, so a frame is never split between sources
         if (boundary) begin
            frame_cnt <= frame_cnt + 8'd1;
            if (enable) owner <= sel_req;
         end
      end
   end
endmodule
